// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI flash read responder (RDID, RDSR, FAST_READ)
//
// Answers a subset of serial-flash commands from a host in SPI mode 0:
//   0x9F RDID      : returns JEDEC_ID MSB byte first, then 0x00
//   0x05 RDSR      : returns STATUS_VAL for every byte
//   0x0B FAST_READ : 3 address bytes, 1 dummy byte, then streamed data
// Any other command is swallowed with MISO disabled until CS goes high.
// The SPI pins are oversampled on clk50 through 2-flop synchronizers.
//
// Ports:
//   clk50          system clock, all logic on its rising edge
//   rst            asynchronous active-high reset
//   spi_sck_i      host SPI clock (mode 0, at most clk50/8)
//   spi_cs_n_i     host chip select, active low
//   spi_mosi_i     host serial data in
//   spi_miso_o     serial data out, held 0 while spi_miso_oe_o is 0
//   spi_miso_oe_o  output enable for spi_miso_o
//   mem_req_o      one-cycle byte read request strobe
//   mem_addr_o     byte address, valid with mem_req_o
//   mem_data_i     read data, valid with mem_ack_i
//   mem_ack_i      one-cycle read completion strobe
//   busy_o         high while chip select is asserted (synchronized)
//   underrun_o     sticky: a data byte was due before its read completed

module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID   = 24'h202018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        spi_sck_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    output logic        mem_req_o,
    output logic [23:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        underrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        STAT,
        IGNORE
    } state_t;

    state_t state;
    state_t state_next;

    // Synchronizers plus one history flop for edge detection
    logic sck_meta, sck_s, sck_d;
    logic cs_meta, cs_s, cs_d;
    logic mosi_meta, mosi_s;

    // Serial datapath
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic        load_pend;
    logic        miso_q;
    logic        oe_q;
    logic [1:0]  byte_cnt;
    logic [15:0] addr_shift;
    logic [1:0]  id_idx;

    // Memory read side
    logic [23:0] next_addr;
    logic        req_due;
    logic        pending;
    logic        discard;
    logic        data_valid;
    logic [7:0]  data_buf;
    logic        mem_req_q;
    logic [23:0] mem_addr_q;
    logic        busy_q;
    logic        underrun_q;

    logic       sck_rise;
    logic       sck_fall;
    logic       cs_start;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       resp_state;
    logic       ack_take;
    logic       load_now;
    logic       data_miss;
    logic       req_fire;
    logic [7:0] load_byte;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            sck_meta  <= 1'b0;
            sck_s     <= 1'b0;
            sck_d     <= 1'b0;
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            cs_d      <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sck_meta  <= spi_sck_i;
            sck_s     <= sck_meta;
            sck_d     <= sck_s;
            cs_meta   <= spi_cs_n_i;
            cs_s      <= cs_meta;
            cs_d      <= cs_s;
            mosi_meta <= spi_mosi_i;
            mosi_s    <= mosi_meta;
        end
    end

    assign sck_rise   = sck_s & ~sck_d;
    assign sck_fall   = ~sck_s & sck_d;
    assign cs_start   = cs_d & ~cs_s;
    assign rx_byte    = {rx_shift, mosi_s};
    assign byte_done  = sck_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign resp_state = (state == DATA) || (state == ID) || (state == STAT);
    // A completion arriving in the very cycle a byte is due still counts
    assign ack_take   = mem_ack_i & pending & ~discard;
    assign load_now   = sck_fall & load_pend & resp_state;
    assign data_miss  = (state == DATA) & ~data_valid & ~ack_take;
    assign req_fire   = req_due & ~pending & ((state == DUMMY) || (state == DATA));

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cs_start) begin
                    state_next = CMD;
                end
            end
            CMD: begin
                if (byte_done) begin
                    case (rx_byte)
                        8'h0B:   state_next = ADDR;
                        8'h9F:   state_next = ID;
                        8'h05:   state_next = STAT;
                        default: state_next = IGNORE;
                    endcase
                end
            end
            ADDR: begin
                if (byte_done && (byte_cnt == 2'd2)) begin
                    state_next = DUMMY;
                end
            end
            DUMMY: begin
                if (byte_done) begin
                    state_next = DATA;
                end
            end
            default: begin
            end
        endcase
        // Chip select release wins over everything
        if (cs_s) begin
            state_next = IDLE;
        end
    end

    // Byte placed on the wire at the start of the next response byte
    always_comb begin
        load_byte = 8'h00;
        case (state)
            ID: begin
                case (id_idx)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = 8'h00;
                endcase
            end
            STAT: load_byte = STATUS_VAL;
            DATA: begin
                if (data_valid) begin
                    load_byte = data_buf;
                end else if (ack_take) begin
                    load_byte = mem_data_i;
                end else begin
                    load_byte = 8'hFF;
                end
            end
            default: load_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            tx_shift   <= 8'd0;
            load_pend  <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            byte_cnt   <= 2'd0;
            addr_shift <= 16'd0;
            id_idx     <= 2'd0;
            next_addr  <= 24'd0;
            req_due    <= 1'b0;
            pending    <= 1'b0;
            discard    <= 1'b0;
            data_valid <= 1'b0;
            data_buf   <= 8'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 24'd0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            busy_q    <= ~cs_s;
            if (cs_s) begin
                // Deselected: drop partial bytes and any read in flight
                bit_cnt    <= 3'd0;
                tx_shift   <= 8'd0;
                load_pend  <= 1'b0;
                miso_q     <= 1'b0;
                oe_q       <= 1'b0;
                byte_cnt   <= 2'd0;
                id_idx     <= 2'd0;
                req_due    <= 1'b0;
                pending    <= 1'b0;
                discard    <= 1'b0;
                data_valid <= 1'b0;
            end else begin
                // Read completion; a late one for an underrun byte is dropped
                if (mem_ack_i && pending) begin
                    pending <= 1'b0;
                    discard <= 1'b0;
                    if (!discard) begin
                        data_buf   <= mem_data_i;
                        data_valid <= 1'b1;
                    end
                end

                if (req_fire) begin
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= next_addr;
                    next_addr  <= next_addr + 24'd1;
                    pending    <= 1'b1;
                    req_due    <= 1'b0;
                end

                if ((state != IDLE) && sck_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        load_pend <= 1'b1;
                    end
                end

                if ((state == ADDR) && byte_done) begin
                    addr_shift <= {addr_shift[7:0], rx_byte};
                    if (byte_cnt == 2'd2) begin
                        next_addr <= {addr_shift, rx_byte};
                        req_due   <= 1'b1;
                        byte_cnt  <= 2'd0;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end

                if (sck_fall) begin
                    load_pend <= 1'b0;
                    if (load_now) begin
                        oe_q     <= 1'b1;
                        miso_q   <= load_byte[7];
                        tx_shift <= {load_byte[6:0], 1'b0};
                        if ((state == ID) && (id_idx != 2'd3)) begin
                            id_idx <= id_idx + 2'd1;
                        end
                        if (state == DATA) begin
                            data_valid <= 1'b0;
                            req_due    <= 1'b1;
                            if (data_miss) begin
                                underrun_q <= 1'b1;
                                // The outstanding read now belongs to a byte already sent
                                discard    <= pending & ~mem_ack_i;
                            end
                        end
                    end else begin
                        miso_q   <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso_o    = miso_q & oe_q;
    assign spi_miso_oe_o = oe_q;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign busy_o        = busy_q;
    assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - self-checking bench for spi_flash_responder

module tb_spi_flash_responder;

    logic        clk50;
    logic        rst;
    logic        spi_sck_i;
    logic        spi_cs_n_i;
    logic        spi_mosi_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic        mem_req_o;
    logic [23:0] mem_addr_o;
    logic [7:0]  mem_data_i;
    logic        mem_ack_i;
    logic        busy_o;
    logic        underrun_o;

    spi_flash_responder dut (
        .clk50         (clk50),
        .rst           (rst),
        .spi_sck_i     (spi_sck_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .busy_o        (busy_o),
        .underrun_o    (underrun_o)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          nbytes;
        bit          ack_on;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          req_cnt = 0;
    int          miso_leak = 0;
    bit          oe_seen = 1'b0;
    bit          ack_en = 1'b1;
    bit          exp_underrun = 1'b0;
    logic [23:0] exp_addr_q[$];
    logic [7:0]  exp_miso_q[$];

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_model(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] exp_resp(input vec_t v, input int i);
        logic [23:0] a;
        a = v.addr + 24'(i);
        case (v.cmd)
            8'h9F: begin
                case (i)
                    0:       return 8'h20;
                    1:       return 8'h20;
                    2:       return 8'h18;
                    default: return 8'h00;
                endcase
            end
            8'h05:   return 8'h00;
            8'h0B:   return v.ack_on ? mem_model(a) : 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Memory model: acks three cycles after each request
    initial begin : mem_model_proc
        logic [23:0] a;
        mem_ack_i  = 1'b0;
        mem_data_i = 8'h00;
        forever begin
            @(negedge clk50);
            if (mem_req_o && ack_en) begin
                a = mem_addr_o;
                repeat (2) @(negedge clk50);
                mem_data_i = mem_model(a);
                mem_ack_i  = 1'b1;
                @(negedge clk50);
                mem_ack_i  = 1'b0;
            end
        end
    end

    // Request scoreboard and output-enable monitor
    initial begin : monitor_proc
        forever begin
            @(negedge clk50);
            if (spi_miso_oe_o) oe_seen = 1'b1;
            if (!spi_miso_oe_o && spi_miso_o) miso_leak++;
            if (mem_req_o) begin
                req_cnt++;
                if (exp_addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stale_req: mem_req_o at addr %h, none expected", mem_addr_o);
                end else begin
                    check("mem_addr", 32'(mem_addr_o), 32'(exp_addr_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    // Mode 0 host: MOSI set while SCK low, MISO sampled at the rising edge
    task automatic xbits(input logic [7:0] tx, input int nbits, input bit last,
                         output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi_i = tx[i];
            #100;
            spi_sck_i = 1'b1;
            rx[i] = spi_miso_o;
            #100;
            if (!(last && i == 8 - nbits)) spi_sck_i = 1'b0;
        end
    endtask

    // Final byte ends with CS raised while SCK is high, so no extra byte is loaded
    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        oe_seen   = 1'b0;
        miso_leak = 0;
        req_cnt   = 0;
        ack_en    = v.ack_on;
        if (v.cmd == 8'h0B) begin
            for (int i = 0; i <= (v.ack_on ? v.nbytes : 0); i++)
                exp_addr_q.push_back(v.addr + 24'(i));
            if (!v.ack_on) exp_underrun = 1'b1;
        end
        @(negedge clk50);
        spi_cs_n_i = 1'b0;
        #200;
        xbits(v.cmd, 8, 1'b0, rx);
        check("busy_active", 32'(busy_o), 32'd1);
        if (v.cmd == 8'h0B) begin
            xbits(v.addr[23:16], 8, 1'b0, rx);
            xbits(v.addr[15:8], 8, 1'b0, rx);
            xbits(v.addr[7:0], 8, 1'b0, rx);
            xbits(8'h00, 8, 1'b0, rx);
        end
        for (int i = 0; i < v.nbytes; i++) begin
            exp_miso_q.push_back(exp_resp(v, i));
            xbits(8'h00, 8, (i == v.nbytes - 1), rx);
            check($sformatf("miso_cmd%h_b%0d", v.cmd, i), 32'(rx), 32'(exp_miso_q.pop_front()));
        end
        spi_cs_n_i = 1'b1;
        #200;
        spi_sck_i = 1'b0;
        #400;
        check("busy_idle", 32'(busy_o), 32'd0);
        check("oe_idle", 32'(spi_miso_oe_o), 32'd0);
        check("oe_seen", 32'(oe_seen), (v.cmd == 8'h9F || v.cmd == 8'h05 || v.cmd == 8'h0B) ? 32'd1 : 32'd0);
        check("miso_leak", 32'(miso_leak), 32'd0);
        check("reqs_outstanding", 32'(exp_addr_q.size()), 32'd0);
        check("underrun", 32'(underrun_o), 32'(exp_underrun));
        exp_addr_q.delete();
        ack_en = 1'b1;
    endtask

    vec_t vecs[6];

    initial begin : stim
        logic [7:0] rx;
        vecs[0] = '{cmd: 8'h9F, addr: 24'h000000, nbytes: 3, ack_on: 1'b1};
        vecs[1] = '{cmd: 8'h0B, addr: 24'h001000, nbytes: 4, ack_on: 1'b1};
        vecs[2] = '{cmd: 8'h0B, addr: 24'hFFFFFF, nbytes: 2, ack_on: 1'b1};
        vecs[3] = '{cmd: 8'h05, addr: 24'h000000, nbytes: 3, ack_on: 1'b1};
        vecs[4] = '{cmd: 8'hAB, addr: 24'h000000, nbytes: 2, ack_on: 1'b1};
        vecs[5] = '{cmd: 8'h0B, addr: 24'h123456, nbytes: 2, ack_on: 1'b0};

        spi_sck_i  = 1'b0;
        spi_cs_n_i = 1'b1;
        spi_mosi_i = 1'b0;
        rst        = 1'b1;
        repeat (4) @(negedge clk50);
        check("rst_miso", 32'(spi_miso_o), 32'd0);
        check("rst_oe", 32'(spi_miso_oe_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk50);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // CS released 13 bits into a FAST_READ, then RDID must be clean
        oe_seen = 1'b0;
        req_cnt = 0;
        @(negedge clk50);
        spi_cs_n_i = 1'b0;
        #200;
        xbits(8'h0B, 8, 1'b0, rx);
        xbits(8'h00, 5, 1'b0, rx);
        #200;
        spi_cs_n_i = 1'b1;
        #400;
        check("abort_req_cnt", 32'(req_cnt), 32'd0);
        check("abort_oe_seen", 32'(oe_seen), 32'd0);
        run_vec(vecs[0]);

        // Reset in the middle of an RDID response
        @(negedge clk50);
        spi_cs_n_i = 1'b0;
        #200;
        xbits(8'h9F, 8, 1'b0, rx);
        #100;
        check("mid_oe_before_rst", 32'(spi_miso_oe_o), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk50);
        check("mid_rst_oe", 32'(spi_miso_oe_o), 32'd0);
        check("mid_rst_underrun", 32'(underrun_o), 32'd0);
        rst = 1'b0;
        exp_underrun = 1'b0;
        #200;
        spi_cs_n_i = 1'b1;
        #400;
        run_vec(vecs[0]);
        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
